// File: rtl/div_seq.sv
// Unsigned restoring divider: DW-bit dividend by Width-bit divisor, one quotient bit per cycle.
// Latency: result valid DW edges after accept; divide-by-zero result valid right after the accept edge.
// Backpressure: result held in DONE until out_ready_i; no new operand accepted until the block is back in IDLE.
module div_seq #(
  parameter  int Width = 8,
  localparam int DW    = 2 * Width + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [DW-1:0]    dividend_i,
  input  logic [Width-1:0] divisor_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [DW-1:0]    quotient_o,
  output logic [Width-1:0] remainder_o,
  output logic             dz_o
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_nxt;

  // acc starts as the dividend and shifts left each iteration; quotient bits
  // enter at the LSB, so after DW iterations it holds the full quotient.
  logic [DW-1:0]    acc;
  logic [Width-1:0] dsr;
  logic [Width:0]   rem;
  logic [CW-1:0]    cnt;
  logic             dz;

  logic [Width:0]   trial;
  logic             ge;
  logic [Width:0]   rem_nxt;
  logic             last;

  // One restoring step: shift the next dividend bit into the partial remainder,
  // then subtract the divisor if it fits. rem[Width] acts as the carry-out of
  // the shift so the compare stays correct for any divisor value.
  always_comb begin
    trial   = {rem[Width-1:0], acc[DW-1]};
    ge      = rem[Width] | (trial >= {1'b0, dsr});
    rem_nxt = ge ? (trial - {1'b0, dsr}) : trial;
    last    = (cnt == CW'(DW - 1));
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: zero divisor skips the iteration phase entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid_i) begin
          state_nxt = (divisor_i == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on accept, iterate in BUSY, hold in DONE, clear on handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc <= '0;
      dsr <= '0;
      rem <= '0;
      cnt <= '0;
      dz  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            rem <= '0;
            cnt <= '0;
            if (divisor_i == '0) begin
              acc <= '1;
              dsr <= '0;
              dz  <= 1'b1;
            end else begin
              acc <= dividend_i;
              dsr <= divisor_i;
              dz  <= 1'b0;
            end
          end
        end
        BUSY: begin
          acc <= {acc[DW-2:0], ge};
          rem <= rem_nxt;
          cnt <= cnt + CW'(1);
        end
        DONE: begin
          if (out_ready_i) begin
            acc <= '0;
            dsr <= '0;
            rem <= '0;
            cnt <= '0;
            dz  <= 1'b0;
          end
        end
        default: begin
          acc <= '0;
          dsr <= '0;
          rem <= '0;
          cnt <= '0;
          dz  <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are only meaningful in DONE; elsewhere they read as zero.
  // in_ready_o is masked by rst_i so it stays low while reset is held.
  always_comb begin
    in_ready_o  = (state == IDLE) && !rst_i;
    out_valid_o = (state == DONE);
    quotient_o  = out_valid_o ? acc : '0;
    remainder_o = out_valid_o ? rem[Width-1:0] : '0;
    dz_o        = out_valid_o ? dz : 1'b0;
  end

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

  localparam int W  = 8;
  localparam int DW = 2 * W + 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] dividend_i;
  logic [W-1:0]  divisor_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] quotient_o;
  logic [W-1:0]  remainder_o;
  logic          dz_o;

  int checks = 0;
  int errors = 0;

  div_seq #(.Width(W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .dz_o        (dz_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [DW-1:0] dvd;
    logic [W-1:0]  dsr;
    logic [DW-1:0] q;
    logic [W-1:0]  r;
    logic          dz;
    int            lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Present one operand pair, wait for the result, check it and its latency
  // (edges after the accept edge), then complete the handshake.
  task automatic run_op(input string tag, input logic [DW-1:0] dvd, input logic [W-1:0] dsr,
                        input logic [DW-1:0] eq, input logic [W-1:0] er, input logic edz,
                        input int elat);
    int  n;
    bit  ok;
    @(negedge clk_i);
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      if (in_ready_o) begin ok = 1; break; end
      @(negedge clk_i);
    end
    if (!ok) begin timeout({tag, "_ready"}); return; end
    in_valid_i  = 1'b1;
    dividend_i  = dvd;
    divisor_i   = dsr;
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    dividend_i = ~dvd;
    divisor_i  = ~dsr;
    n  = 0;
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (out_valid_o) begin ok = 1; break; end
      if (k == 0) begin
        chk({tag, "_busy_q"}, quotient_o, 0);
        chk({tag, "_busy_r"}, remainder_o, 0);
        chk({tag, "_busy_dz"}, dz_o, 0);
        chk({tag, "_busy_rdy"}, in_ready_o, 0);
      end
      @(posedge clk_i);
      n++;
    end
    if (!ok) begin timeout({tag, "_result"}); return; end
    chk({tag, "_lat"}, n, elat);
    chk({tag, "_q"}, quotient_o, eq);
    chk({tag, "_r"}, remainder_o, er);
    chk({tag, "_dz"}, dz_o, edz);
    @(posedge clk_i);
    @(negedge clk_i);
    chk({tag, "_post_vld"}, out_valid_o, 0);
    chk({tag, "_post_q"}, quotient_o, 0);
  endtask

  initial begin
    int  gap;
    int  stale;
    bit  ok;

    vecs[0] = '{17'd1000,   8'd7,   17'd142,    8'd6,  1'b0, 17};
    vecs[1] = '{17'd131071, 8'd255, 17'd514,    8'd1,  1'b0, 17};
    vecs[2] = '{17'd131071, 8'd1,   17'd131071, 8'd0,  1'b0, 17};
    vecs[3] = '{17'd5,      8'd9,   17'd0,      8'd5,  1'b0, 17};
    vecs[4] = '{17'd0,      8'd3,   17'd0,      8'd0,  1'b0, 17};
    vecs[5] = '{17'd77,     8'd0,   17'h1FFFF,  8'd0,  1'b1, 0};
    vecs[6] = '{17'd20,     8'd4,   17'd5,      8'd0,  1'b0, 17};
    vecs[7] = '{17'd65535,  8'd16,  17'd4095,   8'd15, 1'b0, 17};
    vecs[8] = '{17'd12345,  8'd100, 17'd123,    8'd45, 1'b0, 17};
    vecs[9] = '{17'd255,    8'd255, 17'd1,      8'd0,  1'b0, 17};

    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    dividend_i  = '0;
    divisor_i   = '0;

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_rdy", in_ready_o, 0);
    chk("rst_vld", out_valid_o, 0);
    chk("rst_q", quotient_o, 0);
    chk("rst_r", remainder_o, 0);
    chk("rst_dz", dz_o, 0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("rst_release_rdy", in_ready_o, 1);

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dsr, vecs[i].q, vecs[i].r,
             vecs[i].dz, vecs[i].lat);
    end

    // Backpressure: hold DONE for 5 cycles while inputs wiggle
    @(negedge clk_i);
    in_valid_i  = 1'b1;
    dividend_i  = 17'd1000;
    divisor_i   = 8'd7;
    out_ready_i = 1'b0;
    @(posedge clk_i);
    #1;
    dividend_i = 17'd555;
    divisor_i  = 8'd0;
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (out_valid_o) begin ok = 1; break; end
    end
    if (!ok) timeout("bp_result");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      chk($sformatf("bp_vld%0d", c), out_valid_o, 1);
      chk($sformatf("bp_q%0d", c), quotient_o, 142);
      chk($sformatf("bp_r%0d", c), remainder_o, 6);
      chk($sformatf("bp_rdy%0d", c), in_ready_o, 0);
      dividend_i = 17'(c * 911);
      divisor_i  = 8'(c + 3);
      @(posedge clk_i);
    end
    @(negedge clk_i);
    out_ready_i = 1'b1;
    dividend_i  = 17'd20;
    divisor_i   = 8'd4;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("bp_release_vld", out_valid_o, 0);
    chk("bp_release_rdy", in_ready_o, 1);

    // Back-to-back accepts with in_valid_i held high: 19 edges apart
    @(posedge clk_i);
    gap = 0;
    ok  = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (out_valid_o) chk("b2b_q", quotient_o, 5);
      if (in_ready_o) begin ok = 1; break; end
      @(posedge clk_i);
      gap++;
    end
    if (!ok) timeout("b2b_gap");
    else chk("b2b_gap", gap + 1, 19);
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (out_valid_o) begin ok = 1; break; end
    end
    if (!ok) timeout("b2b_result");
    else begin
      chk("b2b2_q", quotient_o, 5);
      chk("b2b2_r", remainder_o, 0);
    end
    @(posedge clk_i);

    // Mid-operation reset at BUSY iteration 8
    @(negedge clk_i);
    in_valid_i  = 1'b1;
    dividend_i  = 17'd1000;
    divisor_i   = 8'd7;
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    repeat (8) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_rdy", in_ready_o, 0);
    chk("mid_rst_vld", out_valid_o, 0);
    chk("mid_rst_q", quotient_o, 0);
    chk("mid_rst_r", remainder_o, 0);
    chk("mid_rst_dz", dz_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("mid_rst_release_rdy", in_ready_o, 1);
    stale = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk_i);
      if (out_valid_o) stale++;
    end
    chk("mid_rst_no_stale", stale, 0);
    run_op("after_rst", 17'd1000, 8'd7, 17'd142, 8'd6, 1'b0, 17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter Width, default 8, sets the divisor and remainder width; DW = 2*Width+1 sets the dividend and quotient width (17 at default, matching the mul_accum result width).
REQ-002 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous and active-high.
REQ-004 in_valid_i  input  1  an operand pair is presented.
REQ-005 in_ready_o  output  1  block can accept an operand pair.
REQ-006 dividend_i  input  DW  unsigned dividend.
REQ-007 divisor_i  input  Width  unsigned divisor.
REQ-008 out_valid_o  output  1  result is valid.
REQ-009 out_ready_i  input  1  consumer takes the result.
REQ-010 quotient_o  output  DW  unsigned quotient.
REQ-011 remainder_o  output  Width  unsigned remainder.
REQ-012 dz_o  output  1  divide-by-zero flag, qualified by out_valid_o.

Function
REQ-013 The FSM SHALL have the states IDLE, BUSY and DONE.
REQ-014 in_ready_o SHALL be 1 only in IDLE, and out_valid_o SHALL be 1 only in DONE.
REQ-015 Accept: on a rising edge in IDLE with in_valid_i=1, the block SHALL capture dividend_i and divisor_i, clear the partial remainder, and go to BUSY, or to DONE if divisor_i=0.
REQ-016 BUSY SHALL be a restoring division, MSB first, producing one quotient bit per cycle; the partial remainder SHALL be Width+1 bits wide so that the trial subtract cannot overflow.
REQ-017 Per iteration: rem = {rem, next dividend bit}; if rem >= divisor, then rem -= divisor and the quotient bit is 1, else the quotient bit is 0.
REQ-018 BUSY SHALL last exactly DW cycles, with the transition to DONE on the edge that computes the last bit; out_valid_o SHALL rise DW edges after the accept edge (17 at default).
REQ-019 Divide by zero SHALL give out_valid_o one edge after accept, with quotient_o all ones, remainder_o = 0 and dz_o = 1.
REQ-020 In every non-zero-divisor case dz_o SHALL be 0, and quotient_o*divisor + remainder_o SHALL equal dividend with remainder_o < divisor.
REQ-021 In DONE, quotient_o, remainder_o and dz_o SHALL hold stable until the handshake completes; the block SHALL go to IDLE on the edge where out_ready_i=1.
REQ-022 Backpressure: out_ready_i=0 SHALL hold DONE indefinitely, with no new accept during that time.
REQ-023 Inputs in BUSY/DONE: changes on dividend_i, divisor_i or in_valid_i SHALL be ignored.
REQ-024 No result/operand overlap: in_ready_o=0 during the DONE->IDLE edge, so the minimum accept-to-accept interval is DW+2 cycles.
REQ-025 Between results, outputs in IDLE and BUSY SHALL be quotient_o=0, remainder_o=0 and dz_o=0.
REQ-026 Dividend 0 with a non-zero divisor SHALL give q=0, r=0 after the normal DW-cycle latency.

Reset
REQ-027 rst_i=1 SHALL immediately, without a clock, force the state to IDLE and clear all datapath registers.
REQ-028 During reset the outputs SHALL be in_ready_o=0, out_valid_o=0, quotient_o=0, remainder_o=0 and dz_o=0.
REQ-029 On the first edge after rst_i deasserts, in_ready_o SHALL be 1.
REQ-030 A reset in BUSY or DONE SHALL abort the operation, with no result produced and no state retained.

Verification
REQ-031 Basic: 1000 / 7 -> q=142, r=6, dz=0, out_valid_o 17 edges after accept.
REQ-032 Max operands: 131071 / 255 -> q=514, r=1; and 131071 / 1 -> q=131071, r=0.
REQ-033 Dividend < divisor: 5 / 9 -> q=0, r=5; and 0 / 3 -> q=0, r=0 after 17 edges.
REQ-034 Divide by zero: 77 / 0 -> q=0x1FFFF, r=0, dz=1, out_valid_o one edge after accept; the next op 20 / 4 -> q=5, r=0, dz=0.
REQ-035 Backpressure: hold out_ready_i=0 for 5 cycles in DONE -> outputs stable and in_ready_o=0; release it -> IDLE on the next edge, with back-to-back accepts exactly 19 cycles apart.
REQ-036 Mid-operation reset: pulse rst_i at BUSY iteration 8 of 1000 / 7 -> all outputs 0 at once, in_ready_o=1 after deassert, no stale result; then 1000 / 7 -> q=142, r=6.
